mips_cpu_hilo_ctrl: RTL and testbench

Multi-cycle sequencer that owns the HI/LO register pair of mips_cpu_harvard and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The decode stage issues one operation with rs/rt operands. The block runs an iterative shift-add multiplier or a restoring divider and raises busy so the CPU stalls MFHI/MFLO and further HI/LO ops. HI/LO values are exported continuously for MFHI/MFLO writeback.

---
 rtl/mips_cpu_pkg.sv | 25 ++
 rtl/mips_cpu_hilo_ctrl_if.sv | 23 ++
 rtl/mips_cpu_hilo_iter.sv | 29 ++
 rtl/mips_cpu_hilo_ctrl.sv | 122 ++++++++++++
 tb/tb_mips_cpu_hilo_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU HI/LO multiply/divide sequencer.
package mips_cpu_pkg;

  localparam int HILO_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX
  } hilo_state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_hilo_ctrl_if.sv
// Decode-stage <-> HI/LO unit bus: operation request plus busy/done and live HI/LO.
interface mips_cpu_hilo_ctrl_if #(parameter int WIDTH = 32);

  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, rs_data, rt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mips_cpu_hilo_iter.sv
// One radix-2 step: shift-add multiply on acc={partial,multiplier}, or restoring
// divide on acc={remainder,dividend/quotient}.
module mips_cpu_hilo_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // NOTE: every output of a combinational block gets a value on every path; a missed branch infers a latch.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = shifted - {1'b0, operand};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // Bit WIDTH of the trial difference is the borrow: set means restore.
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO owner: MTHI/MTLO writes, and iterative MULT/MULTU/DIV/DIVU with sign fix-up.
module mips_cpu_hilo_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = HILO_ITERS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  mips_cpu_hilo_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  hilo_state_t        state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   mag_rs;
  logic [WIDTH-1:0]   mag_rt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    rs_neg = is_signed_op(bus.op) & bus.rs_data[WIDTH-1];
    rt_neg = is_signed_op(bus.op) & bus.rt_data[WIDTH-1];
    mag_rs = rs_neg ? -bus.rs_data : bus.rs_data;
    mag_rt = rt_neg ? -bus.rt_data : bus.rt_data;
    prod   = neg_res ? -acc : acc;
    quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mips_cpu_hilo_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.rs_data;
              OP_MTLO: lo_q <= bus.rs_data;
              OP_MULT, OP_MULTU: begin
                acc     <= {{WIDTH{1'b0}}, mag_rt};
                operand <= mag_rs;
                is_div  <= 1'b0;
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= 1'b0;
                counter <= '0;
                state   <= ST_ITER;
              end
              OP_DIV, OP_DIVU: begin
                acc     <= {{WIDTH{1'b0}}, mag_rs};
                operand <= mag_rt;
                is_div  <= 1'b1;
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= rs_neg;
                counter <= '0;
                state   <= ST_ITER;
              end
              default: ;
            endcase
          end
        end
        ST_ITER: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
          if (counter == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          // A zero divisor leaves HI/LO untouched but still completes with done.
          if (!is_div) begin
            {hi_q, lo_q} <= prod;
          end else if (operand != '0) begin
            hi_q <= rem;
            lo_q <= quot;
          end
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Scoreboarded bench for the HI/LO sequencer: directed plan cases plus random ops vs an arithmetic model.
module tb_mips_cpu_hilo_ctrl;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;

  mips_cpu_hilo_ctrl_if #(.WIDTH(32)) bus ();

  mips_cpu_hilo_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend, matching MIPS DIV.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MTHI: model_hi = a;
      OP_MTLO: model_lo = a;
      OP_MULT: begin
        p = 64'(sa * sb);
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      OP_DIV: begin
        if (b != 0) begin
          sq = sa / sb;
          sr = sa % sb;
          model_lo = sq[31:0];
          model_hi = sr[31:0];
        end
      end
      OP_DIVU: begin
        if (b != 0) begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
      default: ;
    endcase
    if (o < 3'd4) exp_q.push_back({model_hi, model_lo});
  endtask

  // Monitor: every done pulse retires one expected HI/LO pair.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("done_hi", {32'b0, bus.hi}, {32'b0, e[63:32]});
        check("done_lo", {32'b0, bus.lo}, {32'b0, e[31:0]});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs_data  = a;
    bus.rt_data  = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    model_apply(o, a, b);
  endtask

  // Counts busy negedges; optionally stalls clk_enable for 5 cycles or injects an op while busy.
  task automatic wait_done(input int stall_at, input bit inject, output int cnt);
    logic [31:0] h0, l0;
    cnt = 0;
    while (bus.busy && cnt < 300) begin
      if (cnt == stall_at) begin
        clk_enable = 1'b0;
        h0 = bus.hi;
        l0 = bus.lo;
      end
      if (stall_at >= 0 && cnt == stall_at + 5) begin
        check("stall_hi", {32'b0, bus.hi}, {32'b0, h0});
        check("stall_lo", {32'b0, bus.lo}, {32'b0, l0});
        check("stall_busy", {63'b0, bus.busy}, 64'd1);
        clk_enable = 1'b1;
      end
      if (inject && cnt == 3) begin
        bus.op_valid = 1'b1;
        bus.op       = OP_MTLO;
        bus.rs_data  = 32'hDEAD_BEEF;
      end
      if (inject && cnt == 4) bus.op_valid = 1'b0;
      cnt++;
      @(negedge clk);
    end
    check("done_pulse", {63'b0, bus.done}, 64'd1);
    @(negedge clk);
    check("done_clear", {63'b0, bus.done}, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    issue(o, a, b);
    if (o < 3'd4) begin
      wait_done(-1, 1'b0, cnt);
      check("busy_cycles", 64'(cnt), 64'd33);
    end else begin
      check("idle_busy", {63'b0, bus.busy}, 64'd0);
      check("idle_hi", {32'b0, bus.hi}, {32'b0, model_hi});
      check("idle_lo", {32'b0, bus.lo}, {32'b0, model_lo});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [2:0]  o;
    logic [31:0] a, b;

    reset        = 1'b1;
    clk_enable   = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = '0;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", {32'b0, bus.hi}, 64'd0);
    check("reset_lo", {32'b0, bus.lo}, 64'd0);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    reset = 1'b0;

    run_op(OP_MTLO, 32'd5, 32'd0);
    run_op(OP_MTHI, 32'd9, 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", {32'b0, bus.lo}, 64'h8000_0000);

    // Divide by zero keeps the preloaded values; an MTLO while busy is dropped.
    run_op(OP_MTHI, 32'h11, 32'd0);
    run_op(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIV, 32'd1234, 32'd0);
    wait_done(-1, 1'b1, cnt);
    check("div0_busy_cycles", 64'(cnt), 64'd33);
    check("div0_hi", {32'b0, bus.hi}, 64'h11);
    check("div0_lo", {32'b0, bus.lo}, 64'h22);

    // Asynchronous reset mid-MULT.
    run_op(OP_MTLO, 32'h55, 32'd0);
    issue(OP_MULT, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", {63'b0, bus.busy}, 64'd0);
    check("areset_done", {63'b0, bus.done}, 64'd0);
    check("areset_hi", {32'b0, bus.hi}, 64'd0);
    check("areset_lo", {32'b0, bus.lo}, 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3);

    // clk_enable low for 5 cycles stretches the operation.
    issue(OP_DIVU, 32'd1_000_003, 32'd17);
    wait_done(6, 1'b0, cnt);
    check("stall_busy_cycles", 64'(cnt), 64'd38);

    for (int i = 0; i < 14; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(o, a, b);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
